// File: rtl/elastic_pipe_buffer_if.sv
// Handshake bundle for elastic_pipe_buffer.
//   valid_in/ready_in/data_in    : upstream push channel
//   valid_out/ready_out/data_out : downstream pop channel
//   count/almost_full            : occupancy status
// The master modport is the environment side and drives the upstream channel and ready_out.
// The slave modport is the buffer side.
interface elastic_pipe_buffer_if #(
  parameter int DATA_W = 41,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, count, almost_full
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, count, almost_full
  );
endinterface

// File: rtl/elastic_pipe_buffer.sv
// Elastic pipeline buffer. It is a circular FIFO with registered pointers and a registered
// occupancy count. It has no fall-through path, so a payload pushed at one edge becomes
// visible in the next cycle.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset; clears the pointers, the count and storage
//   flush : synchronous discard of every entry (branch redirect)
//   bus   : handshake/status bundle (slave side), see elastic_pipe_buffer_if
module elastic_pipe_buffer #(
  parameter int DATA_W    = 41,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  elastic_pipe_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ready_in and valid_out depend only on the registered count. This keeps the handshake
  // free of combinational paths. When the buffer is full, a same-cycle pop does not
  // admit a push.
  assign bus.ready_in    = (count_q != FULL_CNT);
  assign bus.valid_out   = (count_q != '0);
  assign bus.data_out    = mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AF_CNT);

  // A flush discards any transfer in the same cycle.
  assign push = bus.valid_in  & bus.ready_in  & ~flush;
  assign pop  = bus.valid_out & bus.ready_out & ~flush;

  // NOTE: every signal written here gets a default assignment first, so a path that leaves
  // a signal unassigned cannot infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register then samples
  // pre-edge values, whatever the order in which the always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately reset so that data_out reads 0 while reset is held.
  // Storage is not cleared on flush, because entries are unreachable once the count is zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end
endmodule
